reset_seq_sync: RTL and testbench
=================================

RESET_SEQ_SYNC -- requirements
Module: reset_seq_sync

Interface
REQ-001 SHALL have parameter DEPTH, default 3: synchronizer stages per channel, legal range 2..8.
REQ-002 SHALL have parameter CHANNELS, default 2: number of output reset domains, legal range 1..8.
REQ-003 SHALL have parameter STRETCH, default 4: extra hold cycles after synchronized release, legal range 0..255.
REQ-004 SHALL have parameter GAP, default 2: minimum cycles between release of channel i-1 and channel i, legal range 1..255.
REQ-005 SHALL have port clock, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: master reset, asynchronous, active-high, applied to all channels.
REQ-007 SHALL have port io_in_reset, input, CHANNELS bits: per-channel asynchronous active-high reset requests.
REQ-008 SHALL have port io_out_reset, output, CHANNELS bits: per-channel active-high resets with asynchronous assert and synchronous, sequenced release.
REQ-009 SHALL have port io_done, output, 1 bit: high when every io_out_reset bit is low.

Function
REQ-010 SHALL define src[i] = reset OR io_in_reset[i].
REQ-011 SHALL assert io_out_reset[i] asynchronously while src[i] is high, with no clock edge required.
REQ-012 SHALL give each channel a DEPTH-flop chain, async-set by src[i], shifting in 0 on each clock edge.
REQ-013 SHALL give each channel an FSM with states RESET, STRETCH, WAIT, RUN; io_out_reset[i] is low only in RUN.
REQ-014 SHALL move the FSM RESET->STRETCH at the edge where the chain output becomes low; SHALL bypass STRETCH when STRETCH=0.
REQ-015 SHALL leave STRETCH after exactly STRETCH edges, counted by an 8-bit counter, then enter WAIT.
REQ-016 SHALL move channel 0 from WAIT to RUN in the same edge WAIT is entered, with no gap.
REQ-017 SHALL keep gap_cnt[i] (i>=1), which counts consecutive edges with io_out_reset[i-1] low, saturates at GAP, and clears synchronously when io_out_reset[i-1] is high.
REQ-018 SHALL move channel i>=1 to RUN at the first edge where its stretch is complete and gap_cnt[i] has reached GAP; with defaults, io_out_reset[1] falls 2 edges after io_out_reset[0].
REQ-019 SHALL move channel i>=1 from RUN to WAIT at the next edge (synchronous assert) when io_out_reset[i-1] rises, so that predecessor resets cascade downward.
REQ-020 SHALL send any channel in any state to RESET asynchronously when src[i] rises; the chain and stretch counter restart, so the full latency is re-incurred.
REQ-021 SHALL have no effect on channels below i when io_in_reset[i] is asserted.
REQ-022 SHALL drive io_done as the combinational NOR of io_out_reset.
REQ-023 SHALL produce a full release sequence from a src pulse of any width, including pulses shorter than one clock period.

Reset
REQ-024 SHALL set all chain flops to 1, all FSMs to RESET and all counters to 0 when reset is asserted; io_out_reset is then all-ones and io_done is 0.
REQ-025 SHALL reset only channel i's chain, FSM and stretch counter when io_in_reset[i] is asserted; gap_cnt[i] clears through REQ-017.

Structure
REQ-026 SHALL place the FSM state enum and the parameter limit constants in shared package reset_seq_pkg.
REQ-027 SHALL implement the per-channel chain as sub-module reset_sync_chain (parameter DEPTH; ports clock, reset, io_q), instantiated CHANNELS times.
REQ-028 SHALL elaborate with an error for any parameter outside its legal range.

Verification
REQ-029 SHALL verify the defaults: reset released before edge 1 -> io_out_reset[0] low after edge 7, io_out_reset[1] low after edge 9, io_done high after edge 9.
REQ-030 SHALL verify that a 1 ns reset glitch while all channels are in RUN asserts both outputs immediately, with release again at edges +7 and +9.
REQ-031 SHALL verify that io_in_reset[1] pulsed while in RUN raises only io_out_reset[1], which falls 7 edges after the pulse ends, while io_out_reset[0] stays low.
REQ-032 SHALL verify that io_in_reset[0] pulsed while in RUN raises io_out_reset[0] asynchronously and io_out_reset[1] at the next edge; they release at edges +7 and +9.
REQ-033 SHALL verify that with DEPTH=2, STRETCH=0, CHANNELS=1, io_out_reset[0] falls after edge 2 of the release.
REQ-034 SHALL verify that reset reasserted during STRETCH (edge 5 with defaults) keeps both outputs high, and a fresh 7/9-edge sequence follows its release.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state type and parameter limits for reset_seq_sync
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_STRETCH = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RUN     = 2'd3
    } seq_state_t;

    localparam int DEPTH_MIN    = 2;
    localparam int DEPTH_MAX    = 8;
    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 8;
    localparam int STRETCH_MIN  = 0;
    localparam int STRETCH_MAX  = 255;
    localparam int GAP_MIN      = 1;
    localparam int GAP_MAX      = 255;

endpackage

// File: rtl/reset_sync_chain.sv
// rtl/reset_sync_chain.sv - per-channel reset synchronizer, async set, zeros shifted in
module reset_sync_chain #(
    parameter int DEPTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    output logic [DEPTH-1:0] io_q
);

    logic [DEPTH-1:0] chain_q;

    // Set every stage on reset, then walk zeros from stage 0 toward stage DEPTH-1
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain_q <= '1;
        end else begin
            chain_q <= {chain_q[DEPTH-2:0], 1'b0};
        end
    end

    assign io_q = chain_q;

endmodule

// File: rtl/reset_seq_sync.sv
// rtl/reset_seq_sync.sv - sequenced multi-domain reset release with async assert
module reset_seq_sync #(
    parameter int DEPTH    = 3,
    parameter int CHANNELS = 2,
    parameter int STRETCH  = 4,
    parameter int GAP      = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] io_in_reset,
    output logic [CHANNELS-1:0] io_out_reset,
    output logic                io_done
);

    import reset_seq_pkg::*;

    // Last stretch count before leaving STRETCH; unused when STRETCH is bypassed
    localparam logic [7:0] STRETCH_LAST = (STRETCH == 0) ? 8'd0 : 8'(STRETCH - 1);
    // gap_q reaching GAP_LAST means this edge brings it to GAP
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
    localparam logic [7:0] GAP_SAT  = 8'(GAP);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("reset_seq_sync: DEPTH %0d outside %0d..%0d", DEPTH, DEPTH_MIN, DEPTH_MAX);
    end
    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
        $error("reset_seq_sync: CHANNELS %0d outside %0d..%0d", CHANNELS, CHANNELS_MIN, CHANNELS_MAX);
    end
    if (STRETCH < STRETCH_MIN || STRETCH > STRETCH_MAX) begin : g_bad_stretch
        $error("reset_seq_sync: STRETCH %0d outside %0d..%0d", STRETCH, STRETCH_MIN, STRETCH_MAX);
    end
    if (GAP < GAP_MIN || GAP > GAP_MAX) begin : g_bad_gap
        $error("reset_seq_sync: GAP %0d outside %0d..%0d", GAP, GAP_MIN, GAP_MAX);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             src;
        logic [DEPTH-1:0] chain_q;
        logic             rel_edge;
        logic             pred_hi;
        logic             gap_ok;
        seq_state_t       state_q;
        logic [7:0]       stretch_q;
        logic             out_q;

        assign src = reset | io_in_reset[i];

        reset_sync_chain #(.DEPTH(DEPTH)) u_chain (
            .clock (clock),
            .reset (src),
            .io_q  (chain_q)
        );

        // Chain output is still high but this edge shifts the last one out
        assign rel_edge = chain_q[DEPTH-1] & ~|chain_q[DEPTH-2:0];

        if (i == 0) begin : g_first
            assign pred_hi = 1'b0;
            assign gap_ok  = 1'b1;
        end else begin : g_next
            logic [7:0] gap_q;
            logic [7:0] gap_d;

            assign pred_hi = io_out_reset[i-1];

            // Count consecutive edges with the predecessor released, saturating at GAP
            always_comb begin
                gap_d = gap_q;
                if (pred_hi) begin
                    gap_d = '0;
                end else if (gap_q != GAP_SAT) begin
                    gap_d = gap_q + 8'd1;
                end
            end

            // Gap counter is cleared only by the master reset; predecessor activity clears it otherwise
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    gap_q <= '0;
                end else begin
                    gap_q <= gap_d;
                end
            end

            assign gap_ok = !pred_hi && (gap_q >= GAP_LAST);
        end

        // Channel sequencer: sync chain, then stretch, then wait for predecessor gap
        always_ff @(posedge clock or posedge src) begin
            if (src) begin
                state_q   <= ST_RESET;
                stretch_q <= '0;
                out_q     <= 1'b1;
            end else begin
                case (state_q)
                    ST_RESET: begin
                        if (rel_edge) begin
                            if (STRETCH == 0) begin
                                state_q <= gap_ok ? ST_RUN : ST_WAIT;
                                out_q   <= !gap_ok;
                            end else begin
                                state_q <= ST_STRETCH;
                            end
                        end
                    end
                    ST_STRETCH: begin
                        if (stretch_q == STRETCH_LAST) begin
                            stretch_q <= '0;
                            state_q   <= gap_ok ? ST_RUN : ST_WAIT;
                            out_q     <= !gap_ok;
                        end else begin
                            stretch_q <= stretch_q + 8'd1;
                        end
                    end
                    ST_WAIT: begin
                        if (gap_ok) begin
                            state_q <= ST_RUN;
                            out_q   <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (pred_hi) begin
                            state_q <= ST_WAIT;
                            out_q   <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_RESET;
                        out_q   <= 1'b1;
                    end
                endcase
            end
        end

        assign io_out_reset[i] = out_q;
    end

    assign io_done = ~|io_out_reset;

endmodule

// File: tb/tb_reset_seq_sync.sv
// tb/tb_reset_seq_sync.sv - self-checking bench for reset_seq_sync
module tb_reset_seq_sync;

    localparam int LAT  = 7;   // DEPTH + STRETCH edges from source release to own readiness
    localparam int GAPN = 2;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [1:0] in_rst = 2'b00;
    logic [1:0] out_rst;
    logic       done;

    logic       reset2 = 1'b1;
    logic [0:0] in2    = 1'b0;
    logic [0:0] out2;
    logic       done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reset_seq_sync dut (
        .clock        (clk),
        .reset        (reset),
        .io_in_reset  (in_rst),
        .io_out_reset (out_rst),
        .io_done      (done)
    );

    reset_seq_sync #(.DEPTH(2), .CHANNELS(1), .STRETCH(0), .GAP(2)) dut2 (
        .clock        (clk),
        .reset        (reset2),
        .io_in_reset  (in2),
        .io_out_reset (out2),
        .io_done      (done2)
    );

    // Effective per-channel reset sources and a record of every rising edge
    logic [1:0] src_v;
    assign src_v = {2{reset}} | in_rst;

    int rise0 = 0;
    int rise1 = 0;
    int seen0 = 0;
    int seen1 = 0;
    always @(posedge src_v[0]) rise0 = rise0 + 1;
    always @(posedge src_v[1]) rise1 = rise1 + 1;

    // Model: a channel is released once LAT edges have passed since its source
    // dropped and (for channel 1) the predecessor has been released for GAPN edges.
    int         own0    = 0;
    int         own1    = 0;
    int         streak1 = 0;
    logic [1:0] m_out   = 2'b11;

    always @(posedge clk) begin
        logic [1:0] pend;
        logic [1:0] pre;
        pend[0] = (rise0 != seen0);
        pend[1] = (rise1 != seen1);
        seen0   = rise0;
        seen1   = rise1;
        pre     = m_out | src_v | pend;
        own0    = src_v[0] ? 0 : (pend[0] ? 1 : ((own0 < 1000) ? own0 + 1 : own0));
        own1    = src_v[1] ? 0 : (pend[1] ? 1 : ((own1 < 1000) ? own1 + 1 : own1));
        streak1 = pre[0] ? 0 : ((streak1 < 1000) ? streak1 + 1 : streak1);
        m_out[0] = src_v[0] | (own0 < LAT);
        m_out[1] = src_v[1] | (own1 < LAT) | (streak1 < GAPN);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        logic [1:0] exp;
        exp = m_out | src_v | {(rise1 != seen1), (rise0 != seen0)};
        check("model_out", 32'(out_rst), 32'(exp));
        check("model_done", 32'(done), 32'(exp == 2'b00));
    endtask

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(negedge clk);
            cmp_model();
        end
    endtask

    task automatic slot();
        wait_edges(1);
        #2;
    endtask

    // Expect release of channel 0 after edge 7 and channel 1 after edge 9
    task automatic release_check(input string name);
        wait_edges(6);
        check({name, "_e6"}, 32'(out_rst), 32'(2'b11));
        wait_edges(1);
        check({name, "_e7"}, 32'(out_rst), 32'(2'b10));
        wait_edges(1);
        check({name, "_e8"}, 32'(out_rst), 32'(2'b10));
        wait_edges(1);
        check({name, "_e9"}, 32'(out_rst), 32'(2'b00));
        check({name, "_done"}, 32'(done), 32'(1'b1));
    endtask

    initial begin
        #2;
        check("reset_out", 32'(out_rst), 32'(2'b11));
        check("reset_done", 32'(done), 32'(1'b0));
        check("reset2_out", 32'(out2), 32'(1'b1));
        check("reset2_done", 32'(done2), 32'(1'b0));
        wait_edges(2);

        // Power-on release
        #2;
        reset = 1'b0;
        release_check("poweron");

        // Short master glitch while running
        wait_edges(3);
        slot();
        reset = 1'b1;
        #1;
        check("glitch_async", 32'(out_rst), 32'(2'b11));
        check("glitch_done", 32'(done), 32'(1'b0));
        reset = 1'b0;
        release_check("glitch");

        // Channel 1 local request leaves channel 0 alone
        wait_edges(3);
        slot();
        in_rst = 2'b10;
        #1;
        check("ch1_async", 32'(out_rst), 32'(2'b10));
        wait_edges(1);
        check("ch1_held", 32'(out_rst), 32'(2'b10));
        #2;
        in_rst = 2'b00;
        wait_edges(6);
        check("ch1_e6", 32'(out_rst), 32'(2'b10));
        wait_edges(1);
        check("ch1_e7", 32'(out_rst), 32'(2'b00));

        // Channel 0 local request cascades to channel 1 at the next edge
        wait_edges(3);
        slot();
        in_rst = 2'b01;
        #1;
        check("ch0_async", 32'(out_rst), 32'(2'b01));
        wait_edges(1);
        check("ch0_cascade", 32'(out_rst), 32'(2'b11));
        #2;
        in_rst = 2'b00;
        release_check("ch0");

        // Master reset reasserted during stretch restarts the full sequence
        wait_edges(2);
        slot();
        reset = 1'b1;
        wait_edges(1);
        #2;
        reset = 1'b0;
        wait_edges(4);
        check("stretch_e4", 32'(out_rst), 32'(2'b11));
        #2;
        reset = 1'b1;
        wait_edges(2);
        check("stretch_reasserted", 32'(out_rst), 32'(2'b11));
        #2;
        reset = 1'b0;
        release_check("restart");

        // Minimal configuration: two-flop chain, no stretch, single channel
        slot();
        reset2 = 1'b0;
        wait_edges(1);
        check("min_e1", 32'(out2), 32'(1'b1));
        wait_edges(1);
        check("min_e2", 32'(out2), 32'(1'b0));
        check("min_done", 32'(done2), 32'(1'b1));
        slot();
        in2 = 1'b1;
        #1;
        check("min_glitch_async", 32'(out2), 32'(1'b1));
        in2 = 1'b0;
        wait_edges(1);
        check("min_glitch_e1", 32'(out2), 32'(1'b1));
        wait_edges(1);
        check("min_glitch_e2", 32'(out2), 32'(1'b0));
        wait_edges(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
